sub_engine_arbiter: RTL and testbench
=====================================

Name: sub_engine_arbiter

Overview:
- Shares the packet buffer's engine port (request read, response write, response length, done) between NCLIENT transaction engines, e.g. the IPbus transaction engine and a status/error responder.
- Waits for the buffer's req_avail, grants exactly one client per packet using round-robin priority, and muxes that client's addresses and write strobes onto the buffer.
- Converts the client's done into the buffer's resp_done pulse, then waits for req_avail to drop before re-arming.
- Sits on ipb_clk between the packet buffer and the engines.

Parameters:
- NCLIENT, 2, number of requesting engines (2..4).
- AW, 9, word address / length width of the buffer engine port.
- DW, 32, data width.
- TIMEOUT, 4096, watchdog limit in ipb_clk cycles (used only with the optional feature).

Ports:
- ipb_clk  in  1  clock.
- reset  in  1  sync active-high reset.
- req_avail  in  1  buffer: request packet ready for the engine.
- req_addr  out  AW  to buffer: request read address.
- req_data  in  DW  from buffer: request word, one-cycle read latency.
- req_len  in  AW  from buffer: request length in words.
- resp_addr  out  AW  to buffer: response write address.
- resp_data  out  DW  to buffer: response write data.
- resp_len  out  AW  to buffer: response length in words.
- resp_we  out  1  to buffer: response write enable.
- resp_done  out  1  to buffer: one-cycle pulse ending the packet.
- cl_req  in  NCLIENT  per-client request to own the packet.
- cl_grant  out  NCLIENT  one-hot grant.
- cl_req_addr  in  NCLIENT*AW  flattened; client i occupies [i*AW +: AW].
- cl_resp_addr  in  NCLIENT*AW  flattened, same slicing.
- cl_resp_data  in  NCLIENT*DW  flattened, same slicing.
- cl_resp_len  in  NCLIENT*AW  flattened, same slicing.
- cl_resp_we  in  NCLIENT  per-client write enable.
- cl_done  in  NCLIENT  per-client one-cycle done.
- cl_req_data  out  DW  req_data broadcast to all clients.
- cl_req_len  out  AW  req_len broadcast to all clients.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking: one clock ipb_clk; reset is synchronous and active-high.
- Reset (also mid-packet) forces:
  - state IDLE; cl_grant=0; resp_done=0; busy=0.
  - priority pointer ptr=0; len register=0.
  - resp_we=0 and all mux outputs 0 while no grant is held.
- States:
  - IDLE: if req_avail=1, go to ARB.
  - ARB: search for the first set cl_req starting at ptr, wrapping modulo NCLIENT. If found, register the one-hot grant in cl_grant and go to GRANT (grant visible 2 cycles after req_avail rises). If none, stay in ARB.
  - GRANT: req_addr, resp_addr, resp_data, resp_we are combinationally muxed from the granted client; non-granted inputs are ignored. On cl_done of the granted client: capture its cl_resp_len into the len register, pulse resp_done for exactly 1 cycle on the next edge, clear cl_grant, set ptr=(granted index+1) mod NCLIENT, go to DRAIN.
  - DRAIN: resp_len keeps driving the captured length. Stay until req_avail=0, then go to IDLE. This covers the buffer's one-cycle req_avail lag, so a stale req_avail never grants twice.
- resp_len is driven from the len register in all states.
- cl_done from a non-granted client, or in any state other than GRANT, is ignored.
- Grant is held for the whole packet; cl_req may drop after grant without effect.
- Simultaneous requests: the lowest index at or after ptr wins.
- Wrap: ptr advances from NCLIENT-1 to 0.

Optional Feature:
- Macro: SUB_ENGINE_ARB_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches TIMEOUT-1 without cl_done: len is forced to 0, resp_done is pulsed, the grant is revoked, ptr advances, and the FSM goes to DRAIN.
  - Extra output port timeout_err (1 bit) is set sticky on a timeout and cleared only by reset.
- Not defined: no counter, no timeout_err port; GRANT waits indefinitely for cl_done.

Decomposition:
- Shared package sub_engine_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ARB=2'd1, ST_GRANT=2'd2, ST_DRAIN=2'd3.
  - widths AW=9, DW=32.
- One sub-module sub_rr_pick: combinational round-robin picker, inputs (req vector, ptr), outputs (one-hot, index, valid).

Test Plan:
- Single client: req_avail=1, only cl_req=2'b01 → cl_grant=01 two cycles later; client0 addresses muxed to req_addr/resp_addr/resp_we; cl_done with cl_resp_len=9'd5 → resp_len=5 and a single-cycle resp_done; ptr=1.
- Contention: cl_req=2'b11 on three successive packets, ptr=0 → grants in order 01, 10, 01.
- Drain hold: req_avail stays high 3 cycles after resp_done → no new grant until req_avail=0, then IDLE.
- Spurious input: cl_done and cl_resp_we from the non-granted client1 during client0's grant → no resp_done and resp_we=0.
- Reset mid-GRANT → cl_grant=0, resp_done=0, resp_len=0, ptr=0 on the next edge; a new req_avail is arbitrated normally.
- WATCHDOG_EN with TIMEOUT=16: client never asserts done → resp_done after 16 GRANT cycles with resp_len=0 and timeout_err=1.

Source files
------------

// File: rtl/sub_engine_arb_pkg.sv
// Shared types and default widths for the packet-buffer engine-port arbiter.
package sub_engine_arb_pkg;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sub_engine_arbiter_if.sv
// Engine-port bundle between the packet buffer, the arbiter and its client engines.
interface sub_engine_arbiter_if #(
  parameter int unsigned NCLIENT = 2,
  parameter int unsigned AW      = sub_engine_arb_pkg::AW,
  parameter int unsigned DW      = sub_engine_arb_pkg::DW
);

  logic                  req_avail;
  logic [AW-1:0]         req_addr;
  logic [DW-1:0]         req_data;
  logic [AW-1:0]         req_len;
  logic [AW-1:0]         resp_addr;
  logic [DW-1:0]         resp_data;
  logic [AW-1:0]         resp_len;
  logic                  resp_we;
  logic                  resp_done;
  logic [NCLIENT-1:0]    cl_req;
  logic [NCLIENT-1:0]    cl_grant;
  logic [NCLIENT*AW-1:0] cl_req_addr;
  logic [NCLIENT*AW-1:0] cl_resp_addr;
  logic [NCLIENT*DW-1:0] cl_resp_data;
  logic [NCLIENT*AW-1:0] cl_resp_len;
  logic [NCLIENT-1:0]    cl_resp_we;
  logic [NCLIENT-1:0]    cl_done;
  logic [DW-1:0]         cl_req_data;
  logic [AW-1:0]         cl_req_len;
  logic                  busy;

  // Arbiter side.
  modport master (
    input  req_avail, req_data, req_len,
    input  cl_req, cl_req_addr, cl_resp_addr, cl_resp_data, cl_resp_len, cl_resp_we, cl_done,
    output req_addr, resp_addr, resp_data, resp_len, resp_we, resp_done,
    output cl_grant, cl_req_data, cl_req_len, busy
  );

  // Buffer plus engines side.
  modport slave (
    output req_avail, req_data, req_len,
    output cl_req, cl_req_addr, cl_resp_addr, cl_resp_data, cl_resp_len, cl_resp_we, cl_done,
    input  req_addr, resp_addr, resp_data, resp_len, resp_we, resp_done,
    input  cl_grant, cl_req_data, cl_req_len, busy
  );

endinterface

// File: rtl/sub_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module sub_rr_pick #(
  parameter int unsigned NCLIENT = 2,
  parameter int unsigned IW      = 1
) (
  input  logic [NCLIENT-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NCLIENT-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  always_comb begin
    logic [IW-1:0] cand;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NCLIENT; k++) begin
      cand = IW'((32'(ptr) + k) % NCLIENT);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/sub_engine_arbiter.sv
// Round-robin owner of the packet buffer's engine port, one client per packet.
// Optional watchdog on the grant phase: define SUB_ENGINE_ARB_WATCHDOG_EN.
module sub_engine_arbiter #(
  parameter int unsigned NCLIENT = 2,
  parameter int unsigned AW      = sub_engine_arb_pkg::AW,
  parameter int unsigned DW      = sub_engine_arb_pkg::DW
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
  , parameter int unsigned TIMEOUT = 4096
`endif
) (
  input  logic                ipb_clk,
  input  logic                reset,
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
  output logic                timeout_err,
`endif
  sub_engine_arbiter_if.master bus
);

  import sub_engine_arb_pkg::*;

  localparam int unsigned IW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

  state_t             state_q, state_d;
  logic [NCLIENT-1:0] grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [AW-1:0]      len_q, len_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [NCLIENT-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               done_hit;
  logic [IW-1:0]      ptr_next;

  logic [AW-1:0]      mux_req_addr, mux_resp_addr, mux_resp_len;
  logic [DW-1:0]      mux_resp_data;
  logic               mux_resp_we;

`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        terr_q, terr_d;
  logic        wd_hit;
  assign wd_hit = (wd_q == 16'(TIMEOUT - 1));
`endif

  sub_rr_pick #(.NCLIENT(NCLIENT), .IW(IW)) u_pick (
    .req    (bus.cl_req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign done_hit = (state_q == ST_GRANT) && |(bus.cl_done & grant_q);
  assign ptr_next = (gidx_q == IW'(NCLIENT - 1)) ? '0 : gidx_q + IW'(1);

  // Granted client's buses; all zero while no grant is held.
  always_comb begin
    mux_req_addr  = '0;
    mux_resp_addr = '0;
    mux_resp_data = '0;
    mux_resp_len  = '0;
    mux_resp_we   = 1'b0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (grant_q[i]) begin
        mux_req_addr  = mux_req_addr  | bus.cl_req_addr[i*AW +: AW];
        mux_resp_addr = mux_resp_addr | bus.cl_resp_addr[i*AW +: AW];
        mux_resp_data = mux_resp_data | bus.cl_resp_data[i*DW +: DW];
        mux_resp_len  = mux_resp_len  | bus.cl_resp_len[i*AW +: AW];
        mux_resp_we   = mux_resp_we   | bus.cl_resp_we[i];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    len_d   = len_q;
    done_d  = 1'b0;
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
    wd_d    = wd_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_avail) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          state_d = ST_GRANT;
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (done_hit) begin
          len_d   = mux_resp_len;
          done_d  = 1'b1;
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ST_DRAIN;
        end
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
        else if (wd_hit) begin
          len_d   = '0;
          done_d  = 1'b1;
          grant_d = '0;
          ptr_d   = ptr_next;
          terr_d  = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      ST_DRAIN: begin
        // Buffer drops req_avail a cycle late; wait it out before re-arming.
        if (!bus.req_avail) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge ipb_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
      wd_q    <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      len_q   <= len_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
      wd_q    <= wd_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign bus.req_addr    = mux_req_addr;
  assign bus.resp_addr   = mux_resp_addr;
  assign bus.resp_data   = mux_resp_data;
  assign bus.resp_we     = mux_resp_we;
  assign bus.resp_len    = len_q;
  assign bus.resp_done   = done_q;
  assign bus.cl_grant    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.cl_req_data = bus.req_data;
  assign bus.cl_req_len  = bus.req_len;
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
  assign timeout_err     = terr_q;
`endif

endmodule

// File: tb/tb_sub_engine_arbiter.sv
// Bench for sub_engine_arbiter: directed packets checked against a packet-level model.
module tb_sub_engine_arbiter;

  localparam int N  = 2;
  localparam int AW = 9;
  localparam int DW = 32;
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
  localparam int TO = 16;
  logic timeout_err;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sub_engine_arbiter_if #(.NCLIENT(N), .AW(AW), .DW(DW)) bus ();

  sub_engine_arbiter #(
    .NCLIENT(N), .AW(AW), .DW(DW)
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .ipb_clk     (clk),
    .reset       (reset),
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
    .timeout_err (timeout_err),
`endif
    .bus         (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] aw_sl(input logic [N*AW-1:0] v, input int i);
    return v[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] dw_sl(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Packet-level model: who owns the port, whether we are hunting for an owner
  // or waiting for req_avail to fall, and the rotating first-choice client.
  int   m_owner = -1;
  bit   m_hunt, m_drain, m_done, m_valid, m_terr;
  int   m_ptr, m_len, m_wd;

  task automatic m_finish(input int l);
    m_len   = l;
    m_done  = 1'b1;
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_drain = 1'b1;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_owner = -1; m_hunt = 0; m_drain = 0; m_ptr = 0; m_len = 0;
      m_wd = 0; m_terr = 0; m_valid = 1;
    end else if (!m_valid) begin
      m_done = 1'b0;
    end else if (m_owner >= 0) begin
      if (bus.cl_done[m_owner]) m_finish(int'(aw_sl(bus.cl_resp_len, m_owner)));
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
      else if (m_wd == TO - 1) begin m_terr = 1; m_finish(0); end
      else m_wd++;
`endif
    end else if (m_hunt) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && bus.cl_req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N; m_hunt = 0; m_wd = 0;
        end
    end else if (m_drain) begin
      if (!bus.req_avail) m_drain = 0;
    end else if (bus.req_avail) begin
      m_hunt = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("cl_grant",    64'(bus.cl_grant),  64'(eg));
      chk("resp_done",   64'(bus.resp_done), 64'(m_done));
      chk("resp_len",    64'(bus.resp_len),  64'(AW'(m_len)));
      chk("busy",        64'(bus.busy),      64'(m_owner >= 0 || m_hunt || m_drain));
      chk("req_addr",    64'(bus.req_addr),  64'((m_owner >= 0) ? aw_sl(bus.cl_req_addr, m_owner) : '0));
      chk("resp_addr",   64'(bus.resp_addr), 64'((m_owner >= 0) ? aw_sl(bus.cl_resp_addr, m_owner) : '0));
      chk("resp_data",   64'(bus.resp_data), 64'((m_owner >= 0) ? dw_sl(bus.cl_resp_data, m_owner) : '0));
      chk("resp_we",     64'(bus.resp_we),   64'((m_owner >= 0) ? bus.cl_resp_we[m_owner] : 1'b0));
      chk("cl_req_data", 64'(bus.cl_req_data), 64'(bus.req_data));
      chk("cl_req_len",  64'(bus.cl_req_len),  64'(bus.req_len));
`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
      chk("timeout_err", 64'(timeout_err), 64'(m_terr));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    int n = 0;
    while (bus.cl_grant == '0 && n < 20) begin
      cyc(); settle(); n++;
    end
    if (bus.cl_grant == '0) begin
      tests++; fails++;
      $display("FAIL wait_grant: no grant after %0d cycles", n);
    end
    g = bus.cl_grant;
  endtask

  task automatic packet(input logic [N-1:0] req, output logic [N-1:0] g);
    bus.cl_req = req;
    bus.req_avail = 1'b1;
    wait_grant(g);
    bus.cl_done = g;
    cyc();
    bus.cl_done = '0;
    bus.req_avail = 1'b0;
    bus.cl_req = '0;
    cyc();
    cyc();
  endtask

  logic [N-1:0] g;

  initial begin
    bus.req_avail    = 1'b0;
    bus.req_data     = 32'h1234_5678;
    bus.req_len      = 9'd12;
    bus.cl_req       = '0;
    bus.cl_done      = '0;
    bus.cl_resp_we   = '0;
    bus.cl_req_addr  = {9'h133, 9'h011};
    bus.cl_resp_addr = {9'h144, 9'h022};
    bus.cl_resp_data = {32'hBEEF_0001, 32'hCAFE_0000};
    bus.cl_resp_len  = {9'd7, 9'd5};
    reset = 1'b1;
    repeat (3) cyc();
    settle();
    chk("rst_grant", 64'(bus.cl_grant), 64'(0));
    chk("rst_busy",  64'(bus.busy), 64'(0));
    chk("rst_len",   64'(bus.resp_len), 64'(0));
    reset = 1'b0;

    // Single client 0.
    bus.cl_req = 2'b01; bus.cl_resp_we = 2'b01; bus.req_avail = 1'b1;
    cyc(); settle();
    chk("t1_arb_nogrant", 64'(bus.cl_grant), 64'(0));
    chk("t1_busy", 64'(bus.busy), 64'(1));
    cyc(); settle();
    chk("t1_grant", 64'(bus.cl_grant), 64'(2'b01));
    chk("t1_req_addr", 64'(bus.req_addr), 64'(9'h011));
    chk("t1_resp_addr", 64'(bus.resp_addr), 64'(9'h022));
    chk("t1_resp_we", 64'(bus.resp_we), 64'(1));
    bus.cl_done = 2'b01;
    cyc();
    bus.cl_done = '0; bus.req_avail = 1'b0; bus.cl_req = '0;
    settle();
    chk("t1_resp_done", 64'(bus.resp_done), 64'(1));
    chk("t1_resp_len", 64'(bus.resp_len), 64'(5));
    chk("t1_grant_clr", 64'(bus.cl_grant), 64'(0));
    cyc(); settle();
    chk("t1_done_pulse", 64'(bus.resp_done), 64'(0));
    chk("t1_idle", 64'(bus.busy), 64'(0));
    cyc();

    // Contention from ptr=0.
    do_reset();
    bus.cl_resp_we = 2'b11;
    packet(2'b11, g); chk("t2_first",  64'(g), 64'(2'b01));
    packet(2'b11, g); chk("t2_second", 64'(g), 64'(2'b10));
    packet(2'b11, g); chk("t2_third",  64'(g), 64'(2'b01));

    // Stale req_avail held through drain.
    bus.cl_req = 2'b11; bus.req_avail = 1'b1;
    wait_grant(g);
    chk("t3_grant", 64'(g), 64'(2'b10));
    bus.cl_done = g;
    cyc();
    bus.cl_done = '0;
    settle();
    chk("t3_resp_done", 64'(bus.resp_done), 64'(1));
    chk("t3_resp_len", 64'(bus.resp_len), 64'(7));
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("t3_hold_nogrant", 64'(bus.cl_grant), 64'(0));
      chk("t3_hold_busy", 64'(bus.busy), 64'(1));
    end
    bus.req_avail = 1'b0; bus.cl_req = '0;
    cyc(); settle();
    chk("t3_back_idle", 64'(bus.busy), 64'(0));
    cyc();

    // Non-granted client's done/we ignored.
    bus.cl_req = 2'b01; bus.req_avail = 1'b1; bus.cl_resp_we = 2'b00;
    wait_grant(g);
    chk("t4_grant", 64'(g), 64'(2'b01));
    bus.cl_done = 2'b10; bus.cl_resp_we = 2'b10;
    settle();
    chk("t4_we_blocked", 64'(bus.resp_we), 64'(0));
    cyc();
    bus.cl_done = '0;
    settle();
    chk("t4_no_done", 64'(bus.resp_done), 64'(0));
    chk("t4_grant_held", 64'(bus.cl_grant), 64'(2'b01));
    bus.cl_done = 2'b01;
    cyc();
    bus.cl_done = '0; bus.req_avail = 1'b0; bus.cl_req = '0;
    cyc(); cyc();

    // Reset in the middle of a grant.
    do_reset();
    packet(2'b01, g);
    bus.cl_req = 2'b11; bus.req_avail = 1'b1;
    wait_grant(g);
    chk("t5_grant_c1", 64'(g), 64'(2'b10));
    reset = 1'b1;
    cyc(); settle();
    chk("t5_rst_grant", 64'(bus.cl_grant), 64'(0));
    chk("t5_rst_done", 64'(bus.resp_done), 64'(0));
    chk("t5_rst_len", 64'(bus.resp_len), 64'(0));
    chk("t5_rst_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;
    wait_grant(g);
    chk("t5_after_rst", 64'(g), 64'(2'b01));
    bus.cl_done = g;
    cyc();
    bus.cl_done = '0; bus.req_avail = 1'b0; bus.cl_req = '0;
    cyc(); cyc();

`ifdef SUB_ENGINE_ARB_WATCHDOG_EN
    // Client never finishes: watchdog ends the packet.
    do_reset();
    bus.cl_req = 2'b01; bus.req_avail = 1'b1;
    wait_grant(g);
    begin
      int n = 0;
      while (bus.cl_grant != '0 && n < 100) begin
        n++; cyc(); settle();
      end
      chk("t6_grant_cycles", 64'(n), 64'(16));
    end
    chk("t6_resp_done", 64'(bus.resp_done), 64'(1));
    chk("t6_resp_len", 64'(bus.resp_len), 64'(0));
    chk("t6_timeout_err", 64'(timeout_err), 64'(1));
    bus.req_avail = 1'b0; bus.cl_req = '0;
    cyc(); cyc();
    chk("t6_sticky", 64'(timeout_err), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
